// File: rtl/addr_gen_pkg.sv
// Shared helpers for the multi-counter address generator: request-select width
// and extraction of one counter's field from a packed per-counter parameter.
package addr_gen_pkg;

  localparam int PACK_W = 512;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Field idx of width w from a packed vector, zero-padded to 32 bits.
  function automatic logic [31:0] param_slice(input logic [PACK_W-1:0] vec,
                                              input int idx, input int w);
    logic [PACK_W-1:0] shifted;
    shifted = vec >> (idx * w);
    return shifted[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/addr_gen_cnt.sv
// One base counter: reload-to-start, increment with optional upper limit,
// registered one-cycle wrap pulse.
module addr_gen_cnt #(
  parameter int                    ADDR_WIDTH = 9,
  parameter logic [ADDR_WIDTH-1:0] START      = '0,
  parameter logic [ADDR_WIDTH-1:0] INC        = ADDR_WIDTH'(1),
  parameter logic [ADDR_WIDTH-1:0] LIMIT      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  load,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  wrap
);

  logic [ADDR_WIDTH:0] nxt;

  // One extra bit so a sum past the top of the range still compares above LIMIT.
  assign nxt = {1'b0, cnt} + {1'b0, INC};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= START;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        cnt <= START;
      end else if (inc) begin
        if ((LIMIT != '0) && (nxt > {1'b0, LIMIT})) begin
          cnt  <= START;
          wrap <= 1'b1;
        end else begin
          cnt <= nxt[ADDR_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/addr_gen_multi.sv
// Multi-counter address generator: base[req_sel] + series offset + req_off,
// 3-stage pipeline. Series offset present only when ADDR_GEN_SERIES_EN is defined.
module addr_gen_multi
  import addr_gen_pkg::*;
#(
  parameter int                             ADDR_WIDTH      = 9,
  parameter int                             N_CNT           = 4,
  parameter int                             OFF_WIDTH       = 4,
  parameter logic [N_CNT*ADDR_WIDTH-1:0]    ADDR_START      = '0,
  parameter logic [N_CNT*ADDR_WIDTH-1:0]    ADDR_INC        = {N_CNT{ADDR_WIDTH'(1)}},
  parameter logic [N_CNT*ADDR_WIDTH-1:0]    ADDR_LIMIT      = '0,
  parameter logic [ADDR_WIDTH-1:0]          ADDR_INC_SERIES = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CNT-1:0]               cnt_inc,
  input  logic [N_CNT-1:0]               cnt_load,
  input  logic                           req_valid,
  input  logic [sel_width(N_CNT)-1:0]    req_sel,
  input  logic [OFF_WIDTH-1:0]           req_off,
  input  logic                           series_inc,
  input  logic                           series_rst,
  output logic [ADDR_WIDTH-1:0]          addr_out,
  output logic                           addr_valid,
  output logic [N_CNT-1:0]               cnt_wrap
);

  localparam int SEL_W = sel_width(N_CNT);
  localparam logic [PACK_W-1:0] START_X = PACK_W'(ADDR_START);
  localparam logic [PACK_W-1:0] INC_X   = PACK_W'(ADDR_INC);
  localparam logic [PACK_W-1:0] LIMIT_X = PACK_W'(ADDR_LIMIT);

  logic [ADDR_WIDTH-1:0] cnt_val [N_CNT];
  logic [ADDR_WIDTH-1:0] base_sel;
  logic [ADDR_WIDTH-1:0] series_add;

  for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
    addr_gen_cnt #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .START      (ADDR_WIDTH'(param_slice(START_X, i, ADDR_WIDTH))),
      .INC        (ADDR_WIDTH'(param_slice(INC_X, i, ADDR_WIDTH))),
      .LIMIT      (ADDR_WIDTH'(param_slice(LIMIT_X, i, ADDR_WIDTH)))
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (cnt_inc[i]),
      .load (cnt_load[i]),
      .cnt  (cnt_val[i]),
      .wrap (cnt_wrap[i])
    );
  end

  // Out-of-range selects fall through to a zero base.
  always_comb begin
    base_sel = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (req_sel == SEL_W'(i)) base_sel = cnt_val[i];
    end
  end

`ifdef ADDR_GEN_SERIES_EN
  logic                  series_inc_r;
  logic                  series_rst_r;
  logic [ADDR_WIDTH-1:0] series_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      series_inc_r <= 1'b0;
      series_rst_r <= 1'b0;
      series_r     <= '0;
    end else begin
      series_inc_r <= series_inc;
      series_rst_r <= series_rst;
      if (series_rst_r)      series_r <= '0;
      else if (series_inc_r) series_r <= series_r + ADDR_INC_SERIES;
    end
  end

  assign series_add = series_r;
`else
  logic unused_series;
  assign unused_series = &{1'b0, series_inc, series_rst, ADDR_INC_SERIES};
  assign series_add    = '0;
`endif

  logic                  vld_p0, vld_p1;
  logic [ADDR_WIDTH-1:0] base_p0, sum_p1;
  logic [OFF_WIDTH-1:0]  off_p0, off_p1;

  always_ff @(posedge clk) begin
    // stage 1: capture base (pre-update counter value)
    base_p0 <= base_sel;
    off_p0  <= req_off;
    // stage 2: add series offset
    sum_p1  <= base_p0 + series_add;
    off_p1  <= off_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      addr_valid <= 1'b0;
      addr_out   <= '0;
    end else begin
      vld_p0     <= req_valid;
      vld_p1     <= vld_p0;
      // stage 3: add zero-extended per-access offset
      addr_valid <= vld_p1;
      addr_out   <= sum_p1 + ADDR_WIDTH'(off_p1);
    end
  end

endmodule

// File: tb/tb_addr_gen_multi.sv
// Bench for addr_gen_multi: directed scenarios plus random traffic against a
// cycle-history reference model. Honours ADDR_GEN_SERIES_EN like the design.
module tb_addr_gen_multi;

  localparam int NC  = 512;
  localparam int SER = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt_inc = '0;
  logic [3:0] cnt_load = '0;
  logic       req_valid = 1'b0;
  logic [1:0] req_sel = '0;
  logic [3:0] req_off = '0;
  logic       series_inc = 1'b0;
  logic       series_rst = 1'b0;
  logic [8:0] addr_out;
  logic       addr_valid;
  logic [3:0] cnt_wrap;

  addr_gen_multi #(
    .ADDR_WIDTH      (9),
    .N_CNT           (4),
    .OFF_WIDTH       (4),
    .ADDR_START      ({9'd48, 9'd32, 9'd16, 9'd0}),
    .ADDR_INC        ({9'd100, 9'd7, 9'd1, 9'd4}),
    .ADDR_LIMIT      ({9'd400, 9'd0, 9'd0, 9'd12}),
    .ADDR_INC_SERIES (9'd64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_inc    (cnt_inc),
    .cnt_load   (cnt_load),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_off    (req_off),
    .series_inc (series_inc),
    .series_rst (series_rst),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .cnt_wrap   (cnt_wrap)
  );

  always #5 clk = ~clk;

  int ST  [4] = '{0, 16, 32, 48};
  int INC [4] = '{4, 1, 7, 100};
  int LIM [4] = '{12, 0, 0, 400};

  // History indexed by clock edge: inputs applied before edge t, state after edge t.
  int   cnt_h [NC][4];
  int   ser_h [NC];
  logic rst_h [NC];
  logic vld_h [NC];
  int   sel_h [NC];
  int   off_h [NC];
  logic si_h  [NC];
  logic sr_h  [NC];
  int   t = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic [3:0] inc, input logic [3:0] ld,
                      input logic v, input logic [1:0] sel, input logic [3:0] off,
                      input logic si, input logic sr);
    logic [3:0] ew;
    logic       ev;
    int         n, prev, k, ea;
    if (t >= NC) begin
      $display("FAIL history: observed %0d expected below %0d", t, NC);
      $fatal(1, "history overflow");
    end
    rst = r; cnt_inc = inc; cnt_load = ld; req_valid = v;
    req_sel = sel; req_off = off; series_inc = si; series_rst = sr;
    rst_h[t] = r; vld_h[t] = v; sel_h[t] = int'(sel); off_h[t] = int'(off);
    si_h[t] = si; sr_h[t] = sr;
    @(posedge clk);
    ew = '0;
    for (int i = 0; i < 4; i++) begin
      prev = (t > 0) ? cnt_h[t-1][i] : ST[i];
      if (r || ld[i]) cnt_h[t][i] = ST[i];
      else if (inc[i]) begin
        n = prev + INC[i];
        if (LIM[i] != 0 && n > LIM[i]) begin
          cnt_h[t][i] = ST[i];
          ew[i] = 1'b1;
        end else cnt_h[t][i] = n % 512;
      end else cnt_h[t][i] = prev;
    end
    ser_h[t] = 0;
`ifdef ADDR_GEN_SERIES_EN
    if (!r && t > 0 && !rst_h[t-1]) begin
      if (sr_h[t-1])      ser_h[t] = 0;
      else if (si_h[t-1]) ser_h[t] = (ser_h[t-1] + SER) % 512;
      else                ser_h[t] = ser_h[t-1];
    end
`endif
    #1;
    check("cnt_wrap", 32'(cnt_wrap), 32'(ew));
    ev = 1'b0;
    ea = 0;
    if (t >= 2) begin
      k  = t - 2;
      ev = vld_h[k] && !rst_h[k] && !rst_h[k+1] && !r;
      if (k > 0) ea = (cnt_h[k-1][sel_h[k]] + ser_h[k] + off_h[k]) % 512;
    end
    check("addr_valid", 32'(addr_valid), 32'(ev));
    if (r)       check("addr_out_rst", 32'(addr_out), 32'd0);
    else if (ev) check("addr_out", 32'(addr_out), 32'(ea));
    t++;
  endtask

  task automatic idle();
    tick(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    tick(1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    tick(1'b1, 4'hF, 4'h0, 1'b1, 2'd0, 4'h0, 1'b1, 1'b0);
    check("reset_wrap", 32'(cnt_wrap), 32'd0);

    // base 32 + offset 3, valid on the third edge
    tick(1'b0, 4'h0, 4'h0, 1'b1, 2'd2, 4'd3, 1'b0, 1'b0);
    idle();
    check("req034_early_vld", 32'(addr_valid), 32'd0);
    idle();
    check("req034_addr", 32'(addr_out), 32'd35);
    check("req034_vld", 32'(addr_valid), 32'd1);

    // counter 0: 4, 8, 12, then wrap to 0
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h1, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    check("req035_wrap", 32'(cnt_wrap), 32'd1);
    idle();
    check("req035_wrap_clear", 32'(cnt_wrap), 32'd0);

    // counter 1 to 20, then simultaneous inc+load
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h2, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    tick(1'b0, 4'h2, 4'h2, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    check("req036_no_wrap", 32'(cnt_wrap), 32'd0);
    tick(1'b0, 4'h0, 4'h0, 1'b1, 2'd1, 4'h0, 1'b0, 1'b0);
    idle();
    idle();
    check("req036_base", 32'(addr_out), 32'd16);

    // series offset: two steps then request
    tick(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0);
    tick(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0);
    tick(1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0);
    idle();
    idle();
`ifdef ADDR_GEN_SERIES_EN
    check("req037_series", 32'(addr_out), 32'd129);
`else
    check("req037_series", 32'(addr_out), 32'd1);
`endif
    tick(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b1);
    idle();
    tick(1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0);
    idle();
    idle();
    check("req037_series_rst", 32'(addr_out), 32'd1);

    // read-before-write on back-to-back requests
    tick(1'b0, 4'h1, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0);
    tick(1'b0, 4'h1, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0);
    tick(1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0);
    check("req038_b2b_0", 32'(addr_out), 32'd0);
    idle();
    check("req038_b2b_1", 32'(addr_out), 32'd4);
    idle();
    check("req038_b2b_2", 32'(addr_out), 32'd8);

    // reset mid-stream drops in-flight requests
    tick(1'b0, 4'h0, 4'h0, 1'b1, 2'd3, 4'd5, 1'b0, 1'b0);
    tick(1'b0, 4'h0, 4'h0, 1'b1, 2'd2, 4'd6, 1'b0, 1'b0);
    tick(1'b1, 4'h0, 4'h0, 1'b1, 2'd1, 4'd7, 1'b0, 1'b0);
    check("req038_rst_vld", 32'(addr_valid), 32'd0);
    idle();
    check("req038_stale_1", 32'(addr_valid), 32'd0);
    idle();
    check("req038_stale_2", 32'(addr_valid), 32'd0);

    for (int j = 0; j < 250; j++) begin
      tick(($urandom_range(0, 39) == 0),
           4'($urandom),
           ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0,
           1'($urandom),
           2'($urandom),
           4'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0));
    end
    idle();
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
